// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed multiplier.
// Provides the default operand width and the controller state encoding.
package mult_pkg;

    // Default operand width, matching the register-file data bus.
    localparam int unsigned N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_seq.sv
// Sequential signed multiplier: radix-2 shift-add on operand magnitudes with
// sign correction on completion. One step per RUN cycle, n RUN cycles, then a
// single DONE cycle that pulses Done for register-file writeback.
//
// Ports:
//   Clock    - clock, all state changes on the rising edge
//   nReset   - asynchronous active-low reset
//   Start    - begin a multiply (accepted only in IDLE)
//   A        - signed multiplicand (register-file Rd1)
//   B        - signed multiplier (immediate field)
//   Busy     - high while not IDLE
//   Done     - one-cycle completion pulse (register-file WE)
//   Product  - full 2n-bit signed product
//   Result   - Q1.(n-1) fractional result, saturated for min*min
module mult_seq
    import mult_pkg::*;
#(
    parameter int unsigned n = N
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Start,
    input  logic [n-1:0]     A,
    input  logic [n-1:0]     B,
    output logic             Busy,
    output logic             Done,
    output logic [2*n-1:0]   Product,
    output logic [n-1:0]     Result
);

    localparam int unsigned CntW = $clog2(n) + 1;

    state_t            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [2*n-1:0]    acc_q;
    logic [2*n-1:0]    mcand_q;   // multiplicand magnitude, shifted left each step
    logic [n-1:0]      mplier_q;  // multiplier magnitude, shifted right each step
    logic              neg_q;
    logic              busy_q;
    logic              done_q;
    logic [2*n-1:0]    prod_q;
    logic [n-1:0]      res_q;

    logic [n-1:0]      mag_a;
    logic [n-1:0]      mag_b;
    logic [2*n-1:0]    addend;
    logic [2*n-1:0]    sum;
    logic [2*n-1:0]    prod_fin;
    logic [n-1:0]      res_fin;
    logic              sat;
    logic              last_step;

    always_comb begin
        // The most negative value negates to itself, which is still the correct
        // unsigned magnitude in n bits.
        mag_a     = A[n-1] ? -A : A;
        mag_b     = B[n-1] ? -B : B;
        addend    = mplier_q[0] ? mcand_q : '0;
        sum       = acc_q + addend;
        prod_fin  = neg_q ? -sum : sum;
        // Only min*min gives a positive product with bit 2n-2 set, i.e. +1.0
        // which is not representable in Q1.(n-1).
        sat       = (prod_fin[2*n-1:2*n-2] == 2'b01);
        res_fin   = sat ? {1'b0, {(n-1){1'b1}}} : prod_fin[2*n-2:n-1];
        last_step = (cnt_q == CntW'(n - 1));
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            prod_q   <= '0;
            res_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        mcand_q  <= {{n{1'b0}}, mag_a};
                        mplier_q <= mag_b;
                        neg_q    <= A[n-1] ^ B[n-1];
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q    <= sum;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (last_step) begin
                        prod_q  <= prod_fin;
                        res_q   <= res_fin;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Product = prod_q;
    assign Result  = res_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: scoreboard of expected products pushed at
// stimulus time and popped when Done is observed.
module tb_mult_seq;

    localparam int unsigned W = 8;

    typedef struct {
        logic [2*W-1:0] prod;
        logic [W-1:0]   res;
    } exp_t;

    logic             Clock;
    logic             nReset;
    logic             Start;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             Busy;
    logic             Done;
    logic [2*W-1:0]   Product;
    logic [W-1:0]     Result;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    mult_seq #(.n(W)) dut (
        .Clock   (Clock),
        .nReset  (nReset),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product),
        .Result  (Result)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t m;
        logic signed [2*W-1:0] p;
        p = 16'($signed(a)) * 16'($signed(b));
        m.prod = p;
        m.res  = (a == 8'h80 && b == 8'h80) ? 8'h7F : p[14:7];
        return m;
    endfunction

    // Scoreboard consumer.
    always @(negedge Clock) begin
        if (nReset && Done) begin
            check_eq("sb_level", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check_eq("product", 32'(Product), 32'(mon_e.prod));
                check_eq("result", 32'(Result), 32'(mon_e.res));
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge Clock);
        while (Busy && k < 40) begin
            @(negedge Clock);
            k++;
        end
        check_eq("idle_wait", 32'(Busy), 32'd0);
    endtask

    // Returns at a negedge with Done seen (or the bound expired).
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        do begin
            @(negedge Clock);
            Start = 1'b0;
            cycles++;
            if (Busy) busy_cnt++;
        end while (!Done && cycles < 40);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int cycles;
        int busy_cnt;
        wait_idle();
        A     = a;
        B     = b;
        Start = 1'b1;
        sb.push_back(model(a, b));
        wait_done(cycles, busy_cnt);
        check_eq("latency", 32'(cycles), W + 1);
        check_eq("busy_cycles", 32'(busy_cnt), W + 1);
        @(negedge Clock);
        check_eq("done_pulse", 32'(Done), 32'd0);
        check_eq("busy_clear", 32'(Busy), 32'd0);
    endtask

    initial begin
        int cycles;
        int busy_cnt;
        exp_t e1;

        nReset = 1'b0;
        Start  = 1'b0;
        A      = '0;
        B      = '0;
        #3;
        check_eq("rst_busy", 32'(Busy), 32'd0);
        check_eq("rst_done", 32'(Done), 32'd0);
        check_eq("rst_product", 32'(Product), 32'd0);
        check_eq("rst_result", 32'(Result), 32'd0);
        @(negedge Clock);
        nReset = 1'b1;

        run_op(8'h40, 8'h40);
        run_op(8'hC0, 8'h40);
        run_op(8'h80, 8'h80);
        run_op(8'h7F, 8'h7F);
        run_op(8'h00, 8'h80);
        run_op(8'h80, 8'h01);
        for (int i = 0; i < 4; i++) begin
            run_op(8'($urandom), 8'($urandom));
        end

        // Start held high; operands change mid-RUN.
        wait_idle();
        A     = 8'h11;
        B     = 8'h22;
        Start = 1'b1;
        e1    = model(8'h11, 8'h22);
        sb.push_back(e1);
        repeat (3) @(negedge Clock);
        A = 8'h33;
        B = 8'h44;
        cycles = 0;
        while (!Done && cycles < 40) begin
            @(negedge Clock);
            cycles++;
        end
        check_eq("hold_done_seen", 32'(Done), 32'd1);
        @(negedge Clock);
        check_eq("idle_gap", 32'(Busy), 32'd0);
        sb.push_back(model(8'h33, 8'h44));
        @(negedge Clock);
        check_eq("reaccept", 32'(Busy), 32'd1);
        check_eq("product_held", 32'(Product), 32'(e1.prod));
        check_eq("result_held", 32'(Result), 32'(e1.res));
        Start = 1'b0;
        wait_done(cycles, busy_cnt);
        check_eq("hold_done2", 32'(Done), 32'd1);

        // Reset in RUN cycle 4 aborts without Done.
        wait_idle();
        A     = 8'h55;
        B     = 8'h66;
        Start = 1'b1;
        sb.push_back(model(8'h55, 8'h66));
        @(negedge Clock);
        Start = 1'b0;
        repeat (3) @(negedge Clock);
        check_eq("pre_abort_busy", 32'(Busy), 32'd1);
        nReset = 1'b0;
        sb.delete();
        #1;
        check_eq("abort_busy", 32'(Busy), 32'd0);
        check_eq("abort_done", 32'(Done), 32'd0);
        check_eq("abort_product", 32'(Product), 32'd0);
        check_eq("abort_result", 32'(Result), 32'd0);
        repeat (2) begin
            @(negedge Clock);
            check_eq("abort_no_done", 32'(Done), 32'd0);
        end
        nReset = 1'b1;
        run_op(8'h03, 8'h05);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
